// File: rtl/run_sequencer.sv
// run_sequencer: drives a core under test through NUM_PASSES passes.
// Each pass holds the core in reset for RST_CYCLES cycles and then lets it
// run for RUN_CYCLES counted (unpaused) cycles. The core mode starts at the
// value latched from mode_base and advances by one, wrapping, on each pass.
module run_sequencer #(
  parameter int RST_CYCLES = 2,
  parameter int RUN_CYCLES = 1000,
  parameter int NUM_PASSES = 2,
  parameter int CNT_W      = 16,
  parameter int MODE_W     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic [MODE_W-1:0] mode_base,
  output logic              core_rst,
  output logic [MODE_W-1:0] core_mode,
  output logic              running,
  output logic [7:0]        pass_idx,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_CORE = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } state_t;

  // Reset-hold counter only needs to reach RST_CYCLES-1.
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [RW-1:0]    RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [7:0]       PASS_LAST = 8'(NUM_PASSES - 1);

  state_t          state;
  logic [RW-1:0]   rst_cnt;

  // The core is held in reset everywhere except RUN; running also drops
  // combinationally while pause is high so it matches the counted cycles.
  assign core_rst = (state != RUN);
  assign running  = (state == RUN) && !pause;
  assign done     = (state == DONE);

  // Sequencer FSM with its pass, mode and cycle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rst_cnt   <= '0;
      core_mode <= '0;
      pass_idx  <= '0;
      cycle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state     <= RESET_CORE;
            rst_cnt   <= '0;
            pass_idx  <= '0;
            cycle_cnt <= '0;
            core_mode <= mode_base;
          end
        end

        RESET_CORE: begin
          if (abort) begin
            state <= IDLE;
          end else if (rst_cnt == RST_LAST) begin
            state <= RUN;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end

        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (!pause) begin
            if (cycle_cnt == RUN_LAST) begin
              if (pass_idx == PASS_LAST) begin
                // Final pass: leave the full count visible after completion.
                cycle_cnt <= cycle_cnt + CNT_W'(1);
                state     <= DONE;
              end else begin
                pass_idx  <= pass_idx + 8'd1;
                core_mode <= core_mode + MODE_W'(1);
                cycle_cnt <= '0;
                rst_cnt   <= '0;
                state     <= RESET_CORE;
              end
            end else begin
              cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: directed vector table, hand-written corner
// sequences, and a randomized run against a behavioural reference model.
module tb_run_sequencer;

  localparam int RST_CYCLES = 2;
  localparam int RUN_CYCLES = 5;
  localparam int NUM_PASSES = 2;
  localparam int CNT_W      = 16;
  localparam int MODE_W     = 1;

  logic              clk = 1'b0;
  logic              rst, start, pause, abort;
  logic [MODE_W-1:0] mode_base;
  logic              core_rst, running, done;
  logic [MODE_W-1:0] core_mode;
  logic [7:0]        pass_idx;
  logic [CNT_W-1:0]  cycle_cnt;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  run_sequencer #(
    .RST_CYCLES(RST_CYCLES),
    .RUN_CYCLES(RUN_CYCLES),
    .NUM_PASSES(NUM_PASSES),
    .CNT_W(CNT_W),
    .MODE_W(MODE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pause(pause),
    .abort(abort),
    .mode_base(mode_base),
    .core_rst(core_rst),
    .core_mode(core_mode),
    .running(running),
    .pass_idx(pass_idx),
    .cycle_cnt(cycle_cnt),
    .done(done)
  );

  typedef struct {
    logic r, s, p, a, mb;
    logic crst, mode, run;
    int   pass, cnt;
    logic dn;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic s, logic p, logic a, logic mb,
                              logic crst, logic mode, logic run,
                              int pass, int cnt, logic dn);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.a = a; v.mb = mb;
    v.crst = crst; v.mode = mode; v.run = run;
    v.pass = pass; v.cnt = cnt; v.dn = dn;
    return v;
  endfunction

  // Packs observed outputs: {core_rst, core_mode, running, pass_idx, cycle_cnt, done}
  function automatic logic [27:0] pack(logic crst, logic mode, logic run,
                                       int pass, int cnt, logic dn);
    return {crst, mode, run, 8'(pass), 16'(cnt), dn};
  endfunction

  function automatic logic [27:0] dut_out();
    return pack(core_rst, core_mode[0], running, int'(pass_idx), int'(cycle_cnt), done);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic s, input logic p,
                       input logic a, input logic mb);
    @(negedge clk);
    rst = r; start = s; pause = p; abort = a; mode_base = mb;
    #2;
  endtask

  // Reference model state
  bit m_act, m_done;
  int m_rl, m_pass, m_cnt, m_mode;

  function automatic logic [27:0] model_out(logic p);
    logic in_run;
    in_run = m_act && (m_rl == 0);
    return pack(!in_run, 1'(m_mode), in_run && !p, m_pass, m_cnt, m_done);
  endfunction

  task automatic model_step(input logic r, input logic s, input logic p,
                            input logic a, input logic mb);
    if (r) begin
      m_act = 0; m_done = 0; m_rl = 0; m_pass = 0; m_cnt = 0; m_mode = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_act) begin
      if (s && !a) begin
        m_act = 1; m_rl = RST_CYCLES; m_pass = 0; m_cnt = 0; m_mode = int'(mb);
      end
    end else if (a) begin
      m_act = 0;
    end else if (m_rl > 0) begin
      m_rl--;
    end else if (!p) begin
      m_cnt++;
      if (m_cnt == RUN_CYCLES) begin
        if (m_pass == NUM_PASSES - 1) begin
          m_act = 0; m_done = 1;
        end else begin
          m_pass++; m_cnt = 0; m_rl = RST_CYCLES;
          m_mode = (m_mode + 1) % (1 << MODE_W);
        end
      end
    end
  endtask

  initial begin
    int done_at;
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; mode_base = '0;

    // Power-on reset, then check idle outputs
    drive(1, 1, 1, 1, 1);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("reset_state", dut_out(), pack(1, 0, 0, 0, 0, 0));

    // Directed two-pass sequence, mode wrap, abort and start+abort in IDLE
    tbl.push_back(mk(0,1,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 0,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 0,0,1,0,1,0));
    tbl.push_back(mk(0,1,0,0,1, 0,0,1,0,2,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,3,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,4,0));
    tbl.push_back(mk(0,0,0,0,0, 1,1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,1,0,1,0,0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0,0,0,0,0, 0,1,1,1,k,0));
    tbl.push_back(mk(0,0,0,0,0, 1,1,0,1,5,1));
    tbl.push_back(mk(0,1,0,0,1, 1,1,0,1,5,0));
    tbl.push_back(mk(0,0,1,0,0, 1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,1,0,0,0,0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,k,0));
    tbl.push_back(mk(0,0,1,0,0, 1,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,1,0,0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,k,0));
    tbl.push_back(mk(0,0,0,1,0, 0,0,1,1,3,0));
    tbl.push_back(mk(0,1,0,1,0, 1,0,0,1,3,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,1,3,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].a, tbl[i].mb);
      check($sformatf("vec%0d", i), dut_out(),
            pack(tbl[i].crst, tbl[i].mode, tbl[i].run, tbl[i].pass, tbl[i].cnt, tbl[i].dn));
    end

    // rst mid-RUN overrides start/pause/abort and abandons the pass
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1);
    for (int k = 1; k <= 4; k++) drive(0, 0, 0, 0, 0);
    check("mid_run_in_run", {core_rst, running}, 2'b01);
    drive(1, 1, 1, 1, 1);
    drive(0, 0, 0, 0, 0);
    check("mid_run_rst", dut_out(), pack(1, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0);
    check("mid_run_rst_idle", dut_out(), pack(1, 0, 0, 0, 0, 0));

    // start and abort together in IDLE after reset: stays idle
    drive(0, 1, 0, 1, 1);
    drive(0, 0, 0, 0, 0);
    check("start_abort_idle", dut_out(), pack(1, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("start_abort_no_run", dut_out(), pack(1, 0, 0, 0, 0, 0));

    // Pause for three cycles during pass 0 RUN delays done by three cycles
    drive(0, 1, 0, 0, 0);
    done_at = -1;
    for (int k = 1; k < 40; k++) begin
      drive(0, 0, (k >= 4 && k <= 6), 0, 0);
      if (k == 5) check("pause_frozen", {running, cycle_cnt}, {1'b0, 16'd1});
      if (k == 7) check("pause_resume", {running, cycle_cnt}, {1'b1, 16'd1});
      if (done) begin
        done_at = k;
        break;
      end
    end
    check("pause_done_cycle", done_at, 18);

    // Randomized run against the reference model
    drive(1, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0);
    for (int k = 0; k < 1500; k++) begin
      logic r, s, p, a, mb;
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 3) == 0);
      p  = ($urandom_range(0, 4) == 0);
      a  = ($urandom_range(0, 59) == 0);
      mb = 1'($urandom_range(0, 1));
      drive(r, s, p, a, mb);
      check($sformatf("rand%0d", k), dut_out(), model_out(p));
      model_step(r, s, p, a, mb);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 2, core-reset hold length per pass in clk cycles (>=1).
REQ-002 SHALL have parameter RUN_CYCLES, default 1000, counted run cycles per pass (>=1, < 2^CNT_W).
REQ-003 SHALL have parameter NUM_PASSES, default 2, passes per sequence (1..255).
REQ-004 SHALL have parameter CNT_W, default 16, width of cycle_cnt.
REQ-005 SHALL have parameter MODE_W, default 1, width of mode bus (bit0 = use_forwarding).
REQ-006 SHALL have port clk  in  1  single clock, all state updates on its rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port start  in  1  level, sampled only in IDLE, begins a sequence.
REQ-009 SHALL have port pause  in  1  freezes the run counter while high in RUN.
REQ-010 SHALL have port abort  in  1  terminates any sequence, returns to IDLE.
REQ-011 SHALL have port mode_base  in  MODE_W  core mode for pass 0, latched on start.
REQ-012 SHALL have port core_rst  out  1  reset to core under test, active-high.
REQ-013 SHALL have port core_mode  out  MODE_W  mode to core for the current pass.
REQ-014 SHALL have port running  out  1  high in RUN cycles where pause is low.
REQ-015 SHALL have port pass_idx  out  8  current pass number, 0-based.
REQ-016 SHALL have port cycle_cnt  out  CNT_W  counted run cycles in current pass.
REQ-017 SHALL have port done  out  1  one-cycle pulse at normal sequence completion.

Function
REQ-018 SHALL implement states IDLE, RESET_CORE, RUN, DONE in a registered state variable; all outputs decoded from registered state and counters.
REQ-019 IDLE: core_rst=1, running=0; start=1 and abort=0 -> RESET_CORE next cycle, pass_idx<=0, cycle_cnt<=0, core_mode<=mode_base.
REQ-020 RESET_CORE: core_rst=1 for exactly RST_CYCLES consecutive cycles, then RUN; pause has no effect here.
REQ-021 RUN: core_rst=0; each cycle with pause=0 sets running=1 and increments cycle_cnt; pause=1 holds cycle_cnt, running=0, state.
REQ-022 RUN exit after the RUN_CYCLES-th counted cycle: if pass_idx==NUM_PASSES-1 -> DONE, else pass_idx+1, core_mode+1 modulo 2^MODE_W, cycle_cnt<=0, -> RESET_CORE.
REQ-023 DONE: core_rst=1, done=1 for that single cycle, -> IDLE; cycle_cnt and pass_idx hold final values until next start.
REQ-024 abort=1 in RESET_CORE, RUN or DONE -> IDLE next cycle, done stays 0, counters hold; abort priority over pause, start and RUN exit.
REQ-025 start outside IDLE SHALL be ignored; start held high in IDLE after DONE re-launches a sequence.
REQ-026 mode_base changes after start SHALL not affect core_mode until the next start.
REQ-027 cycle_cnt SHALL never exceed RUN_CYCLES; no counter wraps except core_mode.

Reset
REQ-028 rst=1 at a rising edge SHALL force, from the next cycle: state IDLE, core_rst=1, core_mode=0, running=0, pass_idx=0, cycle_cnt=0, done=0.
REQ-029 rst SHALL override abort, start and pause, and abandon any sequence mid-pass with no done pulse.

Verification (RST_CYCLES=2, RUN_CYCLES=5, NUM_PASSES=2, MODE_W=1)
REQ-030 rst, then start one cycle, mode_base=0 -> core_rst high 2 cycles, running 5 cycles core_mode=0, core_rst 2 cycles, running 5 cycles core_mode=1, done single pulse 15th cycle after start sampled, then IDLE.
REQ-031 pause high 3 cycles during pass 0 RUN -> that RUN lasts 8 cycles, cycle_cnt frozen while paused, done 3 cycles later than REQ-030.
REQ-032 abort in pass 1 RUN at cycle_cnt=3 -> next cycle IDLE, core_rst=1, running=0, done never asserts, cycle_cnt=3.
REQ-033 mode_base=1 -> pass 0 core_mode=1, pass 1 core_mode wraps to 0.
REQ-034 start pulsed during RUN -> no effect; rst asserted mid-RUN -> next cycle all outputs at REQ-028 values.
REQ-035 start and abort both high in IDLE -> remains IDLE, core_rst=1, pass_idx=0.
